// File: rtl/bp_update_queue.sv
// bp_update_queue: buffers resolved conditional branches and feeds them to the
// local branch predictor one per cycle. An issue is held off while the head's
// predictor entry was written within the last HAZARD_CYCLES cycles. Saturating
// branch / mispredict statistics are kept alongside.
// bht_update_o is laid out as the packed struct {valid, pc[VLEN-1:0], taken}.
module bp_update_queue #(
    parameter int unsigned VLEN          = 64,
    parameter bit          RVC           = 1'b1,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned NR_ENTRIES    = 1024,
    parameter int unsigned HAZARD_CYCLES = 2,
    parameter int unsigned CNT_WIDTH     = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_bp_i,
    input  logic                 debug_mode_i,
    input  logic                 resolved_valid_i,
    input  logic [VLEN-1:0]      resolved_pc_i,
    input  logic                 resolved_taken_i,
    input  logic                 resolved_pred_taken_i,
    output logic                 resolved_ready_o,
    output logic [VLEN+1:0]      bht_update_o,
    output logic [CNT_WIDTH-1:0] branch_cnt_o,
    output logic [CNT_WIDTH-1:0] mispredict_cnt_o
);
    localparam int unsigned KEY_BITS = $clog2(NR_ENTRIES);
    localparam int unsigned OFFSET   = RVC ? 1 : 2;
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    // Keep at least one history slot so the arrays stay legal; it is ignored
    // entirely when the hazard check is disabled.
    localparam int unsigned HZ_N     = (HAZARD_CYCLES == 0) ? 1 : HAZARD_CYCLES;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
    } bht_update_t;

    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic            taken;
    } entry_t;

    entry_t               fifo_q [DEPTH];
    logic [PTR_W:0]       wr_ptr_q, rd_ptr_q;
    logic [HZ_N-1:0]      hz_vld_q;
    logic [KEY_BITS-1:0]  hz_key_q [HZ_N];
    bht_update_t          upd_q, upd_d;
    logic [CNT_WIDTH-1:0] bcnt_q, bcnt_d, mcnt_q, mcnt_d;

    logic                 full, empty, accept, issue, hazard_hit;
    entry_t               head;
    logic [KEY_BITS-1:0]  head_key;

    // Occupancy, head lookup and the accept/issue decisions
    always_comb begin
        full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        head     = fifo_q[rd_ptr_q[PTR_W-1:0]];
        head_key = head.pc[KEY_BITS+OFFSET-1:OFFSET];

        hazard_hit = 1'b0;
        for (int i = 0; i < int'(HZ_N); i++) begin
            if (HAZARD_CYCLES != 0 && hz_vld_q[i] && hz_key_q[i] == head_key)
                hazard_hit = 1'b1;
        end

        // Debug-mode branches are consumed (ready stays high) but dropped here.
        accept = resolved_valid_i && !full && !debug_mode_i && !flush_bp_i;
        issue  = !empty && !flush_bp_i && !hazard_hit;
    end

    assign resolved_ready_o = !full;

    // Next update word and saturating statistics
    always_comb begin
        upd_d       = upd_q;
        upd_d.valid = 1'b0;
        if (issue) begin
            upd_d.valid = 1'b1;
            upd_d.pc    = head.pc;
            upd_d.taken = head.taken;
        end

        bcnt_d = bcnt_q;
        mcnt_d = mcnt_q;
        if (accept) begin
            if (~&bcnt_q)
                bcnt_d = bcnt_q + CNT_WIDTH'(1);
            if ((resolved_taken_i != resolved_pred_taken_i) && ~&mcnt_q)
                mcnt_d = mcnt_q + CNT_WIDTH'(1);
        end
    end

    // FIFO storage and pointers; flush drops everything pending
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= '0;
        end else if (flush_bp_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (accept) begin
                fifo_q[wr_ptr_q[PTR_W-1:0]] <= '{pc: resolved_pc_i, taken: resolved_taken_i};
                wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
            end
            if (issue)
                rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    // Hazard history: shifts every cycle, records the issued key or a bubble
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hz_vld_q <= '0;
            for (int i = 0; i < int'(HZ_N); i++) hz_key_q[i] <= '0;
        end else if (flush_bp_i) begin
            hz_vld_q <= '0;
        end else begin
            hz_vld_q[0] <= issue;
            hz_key_q[0] <= head_key;
            for (int i = 1; i < int'(HZ_N); i++) begin
                hz_vld_q[i] <= hz_vld_q[i-1];
                hz_key_q[i] <= hz_key_q[i-1];
            end
        end
    end

    // Registered predictor update and counters; counters survive a flush
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            upd_q  <= '0;
            bcnt_q <= '0;
            mcnt_q <= '0;
        end else begin
            upd_q  <= upd_d;
            bcnt_q <= bcnt_d;
            mcnt_q <= mcnt_d;
        end
    end

    assign bht_update_o     = upd_q;
    assign branch_cnt_o     = bcnt_q;
    assign mispredict_cnt_o = mcnt_q;

endmodule

// File: tb/tb_bp_update_queue.sv
// Bench for bp_update_queue: directed scenarios plus random traffic, every
// cycle compared against a queue-based reference model of the update queue.
module tb_bp_update_queue;
    localparam int VLEN  = 32;
    localparam int DEPTH = 4;
    localparam int NR    = 1024;
    localparam int HZ    = 2;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush, dbg, vld, tk, ptk;
    logic [VLEN-1:0] pc;
    logic            rdy;
    logic [VLEN+1:0] upd;
    logic [CW-1:0]   bcnt, mcnt;

    bp_update_queue #(
        .VLEN(VLEN), .RVC(1'b1), .DEPTH(DEPTH), .NR_ENTRIES(NR),
        .HAZARD_CYCLES(HZ), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_bp_i(flush), .debug_mode_i(dbg),
        .resolved_valid_i(vld), .resolved_pc_i(pc), .resolved_taken_i(tk),
        .resolved_pred_taken_i(ptk), .resolved_ready_o(rdy),
        .bht_update_o(upd), .branch_cnt_o(bcnt), .mispredict_cnt_o(mcnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    typedef struct { logic [31:0] pc; logic tk; } ent_t;
    ent_t        mq[$];
    int          hist[$];       // issued key per past cycle, newest first, -1 = none
    logic        m_v, m_tk;
    logic [31:0] m_pc;
    int          m_bc, m_mc;

    int cyc_n;
    int vcyc[$];                // cycles in which the DUT showed a valid update
    int not_ready;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int keyof(input logic [31:0] a);
        return int'((a >> 1) % NR);
    endfunction

    task automatic m_reset();
        mq.delete();
        hist.delete();
        for (int i = 0; i < HZ; i++) hist.push_back(-1);
        m_v = 0; m_pc = 0; m_tk = 0; m_bc = 0; m_mc = 0;
    endtask

    // One cycle: entered and left at a negedge. Checks outputs, drives inputs,
    // advances the model to what should be visible after the next posedge.
    task automatic cyc(input logic v, input logic [31:0] a, input logic t,
                       input logic pt, input logic d, input logic f);
        bit ready, acc, iss;
        int hk;
        chk("ready", 64'(rdy), 64'(mq.size() < DEPTH));
        chk("upd", 64'(upd), 64'({m_v, m_pc, m_tk}));
        chk("bcnt", 64'(bcnt), 64'(m_bc));
        chk("mcnt", 64'(mcnt), 64'(m_mc));
        if (upd[VLEN+1]) vcyc.push_back(cyc_n);
        if (!rdy) not_ready++;

        vld = v; pc = a; tk = t; ptk = pt; dbg = d; flush = f;

        ready = (mq.size() < DEPTH);
        acc   = v && ready && !d && !f;
        iss   = 0;
        if (!f && mq.size() > 0) begin
            iss = 1;
            foreach (hist[i]) if (hist[i] == keyof(mq[0].pc)) iss = 0;
        end
        if (f) begin
            mq.delete();
            foreach (hist[i]) hist[i] = -1;
            m_v = 0;
        end else begin
            hk = -1;
            m_v = 0;
            if (iss) begin
                hk = keyof(mq[0].pc);
                m_v = 1; m_pc = mq[0].pc; m_tk = mq[0].tk;
                void'(mq.pop_front());
            end
            hist.push_front(hk);
            void'(hist.pop_back());
            if (acc) begin
                mq.push_back('{a, t});
                if (m_bc < CMAX) m_bc++;
                if (t != pt && m_mc < CMAX) m_mc++;
            end
        end
        @(posedge clk);
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    // Async reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        vld = 0; flush = 0; dbg = 0;
        #2 rst = 1;
        #1;
        chk("rst_upd", 64'(upd), 0);
        chk("rst_rdy", 64'(rdy), 1);
        chk("rst_bcnt", 64'(bcnt), 0);
        chk("rst_mcnt", 64'(mcnt), 0);
        m_reset();
        @(negedge clk);
        rst = 0;
        cyc_n = 0;
        vcyc.delete();
        not_ready = 0;
    endtask

    initial begin
        logic [31:0] ra;
        rst = 1; flush = 0; dbg = 0; vld = 0; pc = 0; tk = 0; ptk = 0;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // single branch, accepted in cycle 5 -> visible in cycle 7 only
        idle(5);
        cyc(1, 32'h8000_0010, 1, 0, 0, 0);
        idle(5);
        chk("lat_n", 64'(vcyc.size()), 1);
        chk("lat_cyc", 64'(vcyc[0]), 7);
        chk("lat_bcnt", 64'(bcnt), 1);
        chk("lat_mcnt", 64'(mcnt), 1);

        // four distinct keys back to back: never stalls, issued in order
        vcyc.delete(); not_ready = 0;
        for (int i = 0; i < 4; i++) cyc(1, 32'h10 * (i + 1), i[0], 0, 0, 0);
        idle(6);
        chk("fill_n", 64'(vcyc.size()), 4);
        chk("fill_nr", 64'(not_ready), 0);
        chk("fill_gap", 64'(vcyc[3] - vcyc[0]), 3);

        // same key repeatedly: issue stalls, queue fills, ready drops
        not_ready = 0;
        for (int i = 0; i < 8; i++) cyc(1, 32'h200, 1, 1, 0, 0);
        idle(30);
        chk("full_seen", 64'(not_ready > 0), 1);

        // hazard spacing: 0x100 x3 -> 3 apart
        vcyc.delete();
        for (int i = 0; i < 3; i++) cyc(1, 32'h100, 1, 1, 0, 0);
        idle(10);
        chk("haz_n", 64'(vcyc.size()), 3);
        chk("haz_d1", 64'(vcyc[1] - vcyc[0]), 3);
        chk("haz_d2", 64'(vcyc[2] - vcyc[1]), 3);

        // 0x100, 0x104, 0x100 -> t, t+1, t+3
        vcyc.delete();
        cyc(1, 32'h100, 0, 0, 0, 0);
        cyc(1, 32'h104, 0, 0, 0, 0);
        cyc(1, 32'h100, 0, 0, 0, 0);
        idle(8);
        chk("haz2_n", 64'(vcyc.size()), 3);
        chk("haz2_d1", 64'(vcyc[1] - vcyc[0]), 1);
        chk("haz2_d2", 64'(vcyc[2] - vcyc[1]), 2);

        // debug mode: consumed, not queued or counted
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 32'h300, 1, 0, 1, 0);
        idle(4);
        chk("dbg_n", 64'(vcyc.size()), 0);
        chk("dbg_bcnt", 64'(bcnt), 0);

        // flush with entries pending; counters survive, next branch normal
        for (int i = 0; i < 3; i++) cyc(1, 32'h400, 1, 1, 0, 0);
        vcyc.delete();
        cyc(1, 32'h500, 1, 1, 0, 1);
        idle(6);
        chk("fl_n", 64'(vcyc.size()), 0);
        chk("fl_bcnt", 64'(bcnt), 3);
        cyc_n = 0;
        cyc(1, 32'h400, 0, 1, 0, 0);
        idle(4);
        chk("fl_lat_n", 64'(vcyc.size()), 1);
        chk("fl_lat", 64'(vcyc[0]), 2);

        // saturation: 20 mispredicts on distinct keys
        do_reset();
        for (int i = 0; i < 20; i++) cyc(1, 32'(i * 8), 1, 0, 0, 0);
        idle(4);
        chk("sat_bcnt", 64'(bcnt), 15);
        chk("sat_mcnt", 64'(mcnt), 15);

        // reset with traffic in flight, then quiet: nothing leaks out
        for (int i = 0; i < 6; i++) cyc(1, 32'h600, 1, 0, 0, 0);
        do_reset();
        idle(6);
        chk("mid_rst_n", 64'(vcyc.size()), 0);

        // random traffic on a few colliding keys
        for (int n = 0; n < 1500; n++) begin
            ra = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 3)) << 2);
            cyc($urandom_range(0, 9) < 7, ra, 1'($urandom), 1'($urandom),
                $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0);
        end
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
